imem_loader: RTL and testbench

Serial program loader that writes instruction words into the instruction memory over its write port. It receives a framed UART byte stream from a host, assembles the bytes into little-endian 32-bit words, and issues one-cycle write strobes using the memory's `rw` convention: 1 means read/idle, 0 means write. While a load is in progress it holds the CPU in reset, and it reports completion or error.

---
 rtl/imem_loader.sv | 276 +++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// UART-fed instruction memory loader: SYNC, length N, 4*N little-endian data bytes -> one-cycle imem writes.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte over the data bytes.
module imem_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         WORD_COUNT   = 32,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  words_loaded
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    WC8     = 8'(WORD_COUNT);

    // ---------------- RX front end ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

    logic [1:0]    rx_sync_reg;
    logic          rx_prev_reg;
    logic          rx_s;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          byte_valid_reg, byte_valid_next;
    logic          frame_err_reg, frame_err_next;

    assign rx_s = rx_sync_reg[1];

    // Sync flops clear to 0 so a line held low across reset release is not taken as a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_reg    <= 2'b00;
            rx_prev_reg    <= 1'b0;
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_sync_reg    <= {rx_sync_reg[0], rx};
            rx_prev_reg    <= rx_s;
            rx_state_reg   <= rx_state_next;
            rx_cnt_reg     <= rx_cnt_next;
            rx_bit_reg     <= rx_bit_next;
            rx_shift_reg   <= rx_shift_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_cnt_next     = rx_cnt_reg;
        rx_bit_next     = rx_bit_reg;
        rx_shift_next   = rx_shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_s) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_M1) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_s ? RX_IDLE : RX_BITS;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_BITS: begin
                if (rx_cnt_reg == FULL_M1) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == FULL_M1) begin
                    rx_cnt_next     = '0;
                    byte_valid_next = rx_s;
                    frame_err_next  = !rx_s;
                    rx_state_next   = RX_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // ---------------- Load sequencer ----------------
    typedef enum logic [2:0] {
        L_IDLE, L_LEN, L_DATA, L_WRITE, L_DONE
`ifdef LOADER_CHECKSUM_EN
        , L_CKSUM
`endif
    } ld_state_t;

    ld_state_t   st_reg, st_next;
    logic [7:0]  len_reg, len_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] word_reg, word_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        mem_rw_reg, mem_rw_next;
    logic        cpu_hold_reg, cpu_hold_next;
    logic        load_done_reg, load_done_next;
    logic        load_err_reg, load_err_next;
    logic [7:0]  words_reg, words_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_reg, sum_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_reg        <= L_IDLE;
            len_reg       <= '0;
            byte_cnt_reg  <= '0;
            word_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_rw_reg    <= 1'b1;
            cpu_hold_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
            words_reg     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            st_reg        <= st_next;
            len_reg       <= len_next;
            byte_cnt_reg  <= byte_cnt_next;
            word_reg      <= word_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_rw_reg    <= mem_rw_next;
            cpu_hold_reg  <= cpu_hold_next;
            load_done_reg <= load_done_next;
            load_err_reg  <= load_err_next;
            words_reg     <= words_next;
`ifdef LOADER_CHECKSUM_EN
            sum_reg       <= sum_next;
`endif
        end
    end

    // Write outputs are registered on entry to WRITE so the strobe lines up with that state's cycle.
    always_comb begin
        st_next        = st_reg;
        len_next       = len_reg;
        byte_cnt_next  = byte_cnt_reg;
        word_next      = word_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_rw_next    = 1'b1;
        cpu_hold_next  = cpu_hold_reg;
        load_done_next = load_done_reg;
        load_err_next  = load_err_reg;
        words_next     = words_reg;
`ifdef LOADER_CHECKSUM_EN
        sum_next       = sum_reg;
`endif
        case (st_reg)
            L_IDLE: begin
                if (byte_valid_reg && rx_shift_reg == SYNC_BYTE) begin
                    load_done_next = 1'b0;
                    load_err_next  = 1'b0;
                    words_next     = '0;
                    st_next        = L_LEN;
                end
            end
            L_LEN: begin
                if (frame_err_reg) begin
                    load_err_next = 1'b1;
                    st_next       = L_IDLE;
                end else if (byte_valid_reg) begin
                    if (rx_shift_reg == 8'd0 || rx_shift_reg > WC8) begin
                        load_err_next = 1'b1;
                        st_next       = L_IDLE;
                    end else begin
                        len_next      = rx_shift_reg;
                        cpu_hold_next = 1'b1;
                        byte_cnt_next = '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_next      = '0;
`endif
                        st_next       = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (frame_err_reg) begin
                    load_err_next = 1'b1;
                    cpu_hold_next = 1'b0;
                    st_next       = L_IDLE;
                end else if (byte_valid_reg) begin
                    word_next     = {rx_shift_reg, word_reg[31:8]};
                    byte_cnt_next = byte_cnt_reg + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_next      = sum_reg + rx_shift_reg;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        mem_rw_next    = 1'b0;
                        mem_addr_next  = {24'd0, words_reg};
                        mem_wdata_next = {rx_shift_reg, word_reg[31:8]};
                        st_next        = L_WRITE;
                    end
                end
            end
            L_WRITE: begin
                words_next = words_reg + 8'd1;
                if (words_reg + 8'd1 == len_reg) begin
`ifdef LOADER_CHECKSUM_EN
                    st_next = L_CKSUM;
`else
                    st_next = L_DONE;
`endif
                end else begin
                    st_next = L_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            L_CKSUM: begin
                if (frame_err_reg) begin
                    load_err_next = 1'b1;
                    cpu_hold_next = 1'b0;
                    st_next       = L_IDLE;
                end else if (byte_valid_reg) begin
                    if (rx_shift_reg == sum_reg) begin
                        st_next = L_DONE;
                    end else begin
                        load_err_next = 1'b1;
                        cpu_hold_next = 1'b0;
                        st_next       = L_IDLE;
                    end
                end
            end
`endif
            L_DONE: begin
                load_done_next = 1'b1;
                cpu_hold_next  = 1'b0;
                st_next        = L_IDLE;
            end
            default: st_next = L_IDLE;
        endcase
    end

    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_rw       = mem_rw_reg;
    assign cpu_hold     = cpu_hold_reg;
    assign load_done    = load_done_reg;
    assign load_err     = load_err_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-stream protocol model plus a per-cycle write monitor.
module tb_imem_loader;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rw, cpu_hold, load_done, load_err;
    logic [7:0]  words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(32), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    int total = 0;
    int bad = 0;

    // Model state
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          m_done, m_err, m_hold;
    int          m_words;

    // Monitor observations
    int          writes_seen = 0;
    int          hold_cycles = 0;
    bit          rw_low_prev = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    logic [7:0]  bq[$];
    bit          okq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Every write strobe is matched against the model's expected write list.
    always @(negedge clk) begin
        if (reset) begin
            if (cpu_hold) hold_cycles <= hold_cycles + 1;
            if (mem_rw == 1'b0) begin
                writes_seen <= writes_seen + 1;
                last_addr   <= mem_addr;
                last_data   <= mem_data_sample();
                if (rw_low_prev) check("write_pulse_width", 32'd2, 32'd1);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr", mem_addr, exp_addr_q.pop_front());
                    check("write_data", mem_wdata, exp_data_q.pop_front());
                end
            end
            rw_low_prev <= (mem_rw == 1'b0);
        end else begin
            rw_low_prev <= 1'b0;
        end
    end

    function automatic logic [31:0] mem_data_sample();
        return mem_wdata;
    endfunction

    function automatic void all_ok();
        okq.delete();
        foreach (bq[i]) okq.push_back(1'b1);
    endfunction

    function automatic void model_reset();
        m_done = 0; m_err = 0; m_hold = 0; m_words = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
    endfunction

    // Walks the whole byte stream by the frame rules and records writes and final status.
    task automatic model_stream();
        int i;
        int n;
        bit aborted;
        logic [31:0] w;
        logic [7:0] sum;
        i = 0;
        w = '0;
        while (i < bq.size()) begin
            if (!okq[i] || bq[i] != 8'hA5) begin i++; continue; end
            m_done = 0; m_err = 0; m_words = 0;
            i++;
            if (i >= bq.size()) return;
            if (!okq[i]) begin m_err = 1; i++; continue; end
            n = int'(bq[i]);
            i++;
            if (n == 0 || n > 32) begin m_err = 1; continue; end
            m_hold = 1;
            sum = 8'd0;
            aborted = 0;
            for (int k = 0; k < 4 * n; k++) begin
                if (i >= bq.size()) return;
                if (!okq[i]) begin m_err = 1; m_hold = 0; aborted = 1; i++; break; end
                w[8 * (k % 4) +: 8] = bq[i];
                sum = sum + bq[i];
                i++;
                if (k % 4 == 3) begin
                    exp_addr_q.push_back(32'(m_words));
                    exp_data_q.push_back(w);
                    m_words++;
                end
            end
            if (aborted) continue;
`ifdef LOADER_CHECKSUM_EN
            if (i >= bq.size()) return;
            if (!okq[i] || bq[i] != sum) begin m_err = 1; m_hold = 0; i++; continue; end
            i++;
`endif
            m_done = 1;
            m_hold = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            rx = b[j];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_range(input int from, input int upto);
        for (int i = from; i < upto; i++) send_byte(bq[i], okq[i]);
    endtask

    task automatic check_status(input string tag);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check({tag, ".load_done"}, 32'(load_done), 32'(m_done));
        check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(m_hold));
        check({tag, ".words_loaded"}, 32'(words_loaded), 32'(m_words));
        check({tag, ".pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic run_frame(input string tag);
        model_stream();
        send_range(0, bq.size());
        check_status(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".mem_addr"}, mem_addr, 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".mem_rw"}, 32'(mem_rw), 32'd1);
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, ".load_done"}, 32'(load_done), 32'd0);
        check({tag, ".load_err"}, 32'(load_err), 32'd0);
        check({tag, ".words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic load_basic();
        bq = '{8'hA5, 8'h02, 8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        bq.push_back(8'h48);
`endif
        all_ok();
    endtask

    int w0, h0;

    initial begin
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);

        // Basic load
        w0 = writes_seen;
        load_basic();
        run_frame("basic");
        check("basic.write_count", 32'(writes_seen - w0), 32'd2);
        check("basic.last_addr", last_addr, 32'd1);
        check("basic.last_data", last_data, 32'h00110113);
        check("basic.done_literal", 32'(load_done), 32'd1);

        // Sync hunting
        w0 = writes_seen;
        load_basic();
        bq.push_front(8'hFF);
        bq.push_front(8'h00);
        all_ok();
        run_frame("hunt");
        check("hunt.write_count", 32'(writes_seen - w0), 32'd2);

        // Bad lengths
        w0 = writes_seen; h0 = hold_cycles;
        bq = '{8'hA5, 8'h00}; all_ok();
        run_frame("len0");
        check("len0.hold_cycles", 32'(hold_cycles - h0), 32'd0);
        check("len0.err_literal", 32'(load_err), 32'd1);
        bq = '{8'hA5, 8'h21}; all_ok();
        run_frame("len33");
        check("len33.hold_cycles", 32'(hold_cycles - h0), 32'd0);
        check("badlen.write_count", 32'(writes_seen - w0), 32'd0);

        // Framing error in word 1 of a 3-word load, then recovery
        w0 = writes_seen;
        bq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        all_ok();
        okq[8] = 1'b0;
        run_frame("framing");
        check("framing.write_count", 32'(writes_seen - w0), 32'd1);
        check("framing.last_data", last_data, 32'h04030201);
        load_basic();
        run_frame("recover");
        check("recover.err_literal", 32'(load_err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch
        load_basic();
        bq[10] = 8'h00;
        run_frame("cksum_bad");
        check("cksum_bad.done_literal", 32'(load_done), 32'd0);
`endif

        // Start glitch inside a frame must not inject a byte
        w0 = writes_seen;
        bq = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
        bq.push_back(8'hAA);
`endif
        all_ok();
        model_stream();
        send_range(0, 3);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(posedge clk);
        send_range(3, bq.size());
        check_status("glitch");
        check("glitch.last_data", last_data, 32'h44332211);
        check("glitch.write_count", 32'(writes_seen - w0), 32'd1);

        // Reset asserted mid-word
        bq = '{8'hA5, 8'h02, 8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h01};
        all_ok();
        run_frame("partial");
        check("partial.hold_literal", 32'(cpu_hold), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        load_basic();
        run_frame("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
